// File: rtl/stream_splitter_pkg.sv
// Shared types and helpers for the N-channel stream splitter.
package stream_splitter_pkg;

  typedef enum logic {
    SPLIT  = 1'b0,
    SERIAL = 1'b1
  } mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Pointer width with one extra wrap bit to tell full from empty.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stream_splitter_n_fifo.sv
// Per-channel synchronous FIFO; extra pointer MSB distinguishes full from empty.
module sync_fifo
  import stream_splitter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned AW = PW - 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign rdata = r_mem[r_rd_ptr[AW-1:0]];

  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: reads are masked by empty at the top level.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/stream_splitter_n.sv
// Splits a wide word into per-channel FIFOs (SPLIT) or streams its lanes out of channel 0 (SERIAL).
module stream_splitter_n
  import stream_splitter_pkg::*;
#(
  parameter int unsigned IN_W   = 64,
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned LANE_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IN_W-1:0]          slave_data,
  input  logic                     valid_in,
  output logic                     ready_in,
  input  logic                     mode,
  input  logic [NUM_CH-1:0]        ch_en,
  output logic [NUM_CH*LANE_W-1:0] data_port,
  output logic [NUM_CH-1:0]        valid_out,
  input  logic [NUM_CH-1:0]        ready_out,
  output logic                     busy
);

  localparam int unsigned CW = $clog2(NUM_CH);
  localparam logic [CW-1:0] LAST_LANE = CW'(NUM_CH - 1);

  state_e            r_state;
  logic [CW-1:0]     r_lane_cnt;
  logic [IN_W-1:0]   r_hold;

  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_empty;
  logic [NUM_CH-1:0] w_push;
  logic [NUM_CH-1:0] w_pop;
  logic [LANE_W-1:0] w_wdata [NUM_CH];
  logic [LANE_W-1:0] w_rdata [NUM_CH];
  logic [LANE_W-1:0] w_hold_lane;
  logic              w_serial_sel;
  logic              w_split_ok;
  logic              w_shift_go;
  logic              w_accept;

  assign w_serial_sel = (mode_e'(mode) == SERIAL);
  // Only enabled channels can stall the input; disabled lanes are dropped.
  assign w_split_ok   = &(~ch_en | ~w_full);
  assign w_shift_go   = (r_state == SHIFT) && !w_full[0];
  assign w_hold_lane  = r_hold[int'(r_lane_cnt)*LANE_W +: LANE_W];

  assign ready_in = !rst && (r_state == IDLE) && (w_serial_sel ? !w_full[0] : w_split_ok);
  assign w_accept = valid_in && ready_in;
  assign busy     = !rst && (r_state == SHIFT);

  // Push decode: SHIFT drains the hold register into channel 0, IDLE accepts fan out.
  always_comb begin
    w_push = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      w_wdata[k] = slave_data[k*LANE_W +: LANE_W];
    end
    if (w_shift_go) begin
      w_push[0]  = 1'b1;
      w_wdata[0] = w_hold_lane;
    end else if (w_accept) begin
      if (w_serial_sel) w_push[0] = 1'b1;
      else              w_push    = ch_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_lane_cnt <= '0;
      r_hold     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept && w_serial_sel) begin
            r_hold     <= slave_data;
            r_lane_cnt <= CW'(1);
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (!w_full[0]) begin
            if (r_lane_cnt == LAST_LANE) begin
              r_lane_cnt <= '0;
              r_state    <= IDLE;
            end else begin
              r_lane_cnt <= r_lane_cnt + CW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  genvar g;
  generate
    for (g = 0; g < int'(NUM_CH); g++) begin : gen_ch
      sync_fifo #(
        .WIDTH (LANE_W),
        .DEPTH (DEPTH)
      ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push[g]),
        .wdata (w_wdata[g]),
        .pop   (w_pop[g]),
        .rdata (w_rdata[g]),
        .full  (w_full[g]),
        .empty (w_empty[g])
      );

      assign valid_out[g] = !rst && !w_empty[g];
      assign w_pop[g]     = !w_empty[g] && ready_out[g];
      assign data_port[g*LANE_W +: LANE_W] = valid_out[g] ? w_rdata[g] : '0;
    end
  endgenerate

endmodule
